cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 cpu_req  input  1  CPU request valid; sampled only in IDLE.
REQ-004 cpu_rw  input  1  0 = read, 1 = write.
REQ-005 cpu_addr  input  10  byte address: tag [9:6], index [5:4], word [3:2], byte [1:0] (byte ignored).
REQ-006 cpu_ready  output  1  one-cycle pulse; request complete.
REQ-007 cpu_hit  output  1  valid with cpu_ready: 1 = hit, 0 = miss.
REQ-008 mem_req  output  1  memory beat request; held until mem_ack.
REQ-009 mem_rw  output  1  0 = refill read, 1 = write-back.
REQ-010 mem_addr  output  10  word-aligned beat address ({tag, index, beat, 2'b00}).
REQ-011 mem_ack  input  1  memory accepts the current beat; ignored while mem_req = 0.
REQ-012 arr_way  output  1  data-array way select.
REQ-013 arr_index  output  2  data-array set select.
REQ-014 arr_word  output  2  data-array word select.
REQ-015 arr_we  output  1  write CPU data into the array this cycle.
REQ-016 arr_fill_we  output  1  write memory data into the array this cycle.

Function
REQ-017 Geometry: 2-way set-associative, 4 sets, 4-word blocks, write-back, write-allocate, LRU replacement.
REQ-018 Internal per-line state: 4-bit tag, valid, dirty; per-set LRU bit naming the least-recently-used way.
REQ-019 FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
REQ-020 IDLE: if cpu_req = 1, latch cpu_rw and cpu_addr, then go to LOOKUP; otherwise stay in IDLE.
REQ-021 LOOKUP hit (valid line with matching tag in either way): same cycle, cpu_ready = 1, cpu_hit = 1, array select = hit way, arr_we = cpu_rw, set dirty if write; go to IDLE. Hit latency is 2 cycles from request capture.
REQ-022 LOOKUP miss: pick the victim as invalid way 0 first, else invalid way 1, else the LRU way; go to WRITEBACK if the victim is valid and dirty, else go to REFILL.
REQ-023 WRITEBACK: 4 beats, words 0..3 in order; mem_rw = 1; mem_addr = {victim tag, index, beat, 00}; array driven with victim way/index/beat; beat advances on mem_ack; after beat 3, go to REFILL.
REQ-024 REFILL: 4 beats, words 0..3; mem_rw = 0; mem_addr = {latched tag, index, beat, 00}; arr_fill_we = mem_ack; after beat 3, write the victim tag, set valid = 1 and dirty = 0, then go to RESPOND.
REQ-025 RESPOND: cpu_ready = 1, cpu_hit = 0; perform the access on the victim way (arr_we = cpu_rw, set dirty if write); go to IDLE.
REQ-026 The LRU bit of the set is updated to the other way on every completed access (LOOKUP hit or RESPOND).
REQ-027 cpu_req is ignored outside IDLE; a cpu_req during the cpu_ready cycle is not captured; it is captured on the next IDLE cycle.
REQ-028 mem_req deasserts for exactly one cycle between beats (the cycle after mem_ack); mem_ack with mem_req = 0 changes nothing.
REQ-029 Unlimited memory wait states are tolerated; mem_req, mem_addr and mem_rw stay stable until mem_ack.
REQ-030 arr_we and arr_fill_we are never asserted in the same cycle.

Reset
REQ-031 When reset = 1 at a clock edge: state = IDLE, all valid, dirty and LRU bits = 0, beat counter = 0.
REQ-032 During reset, all outputs are 0: cpu_ready, cpu_hit, mem_req, mem_rw, mem_addr, arr_*.
REQ-033 Reset during WRITEBACK or REFILL abandons the transfer; mem_req = 0 from the next cycle; no partial tag update is kept.

Verification
REQ-034 Read 0x000 after reset -> miss, no WRITEBACK, 4 refill beats at 0x000/0x004/0x008/0x00C, then cpu_ready with cpu_hit = 0, way 0.
REQ-035 Write 0x000 -> LOOKUP hit, cpu_hit = 1, arr_we = 1 on way 0, line 0 marked dirty, no mem_req.
REQ-036 Read 0x200 -> miss, fills way 1 of set 0, no write-back; then read 0x000 -> hit on way 0.
REQ-037 Read 0x300 -> evicts way 1 (clean, holding 0x200), no write-back; then read 0x200 -> victim is way 0 (dirty 0x000): write-back beats at 0x000 to 0x00C, refill at 0x200 to 0x20C, cpu_hit = 0.
REQ-038 Random 0 to 5 cycle mem_ack delays, and reset asserted mid-REFILL -> mem_req drops the next cycle and a following read of the same address misses.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: CPU request/response, memory beat handshake and
// data-array control strobes.
interface cache_ctrl_if;
  logic       cpu_req;
  logic       cpu_rw;
  logic [9:0] cpu_addr;
  logic       cpu_ready;
  logic       cpu_hit;
  logic       mem_req;
  logic       mem_rw;
  logic [9:0] mem_addr;
  logic       mem_ack;
  logic       arr_way;
  logic [1:0] arr_index;
  logic [1:0] arr_word;
  logic       arr_we;
  logic       arr_fill_we;

  // Requester side: CPU plus memory acknowledge
  modport master (
    output cpu_req, cpu_rw, cpu_addr, mem_ack,
    input  cpu_ready, cpu_hit, mem_req, mem_rw, mem_addr,
           arr_way, arr_index, arr_word, arr_we, arr_fill_we
  );

  // Controller side
  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, mem_ack,
    output cpu_ready, cpu_hit, mem_req, mem_rw, mem_addr,
           arr_way, arr_index, arr_word, arr_we, arr_fill_we
  );
endinterface

// File: rtl/cache_ctrl.sv
// Controller for a 2-way, 4-set, 4-word-block write-back/write-allocate cache
// with per-set LRU; moves whole blocks to/from memory one beat at a time.
module cache_ctrl (
  input  logic         clk,
  input  logic         reset,
  cache_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
  } state_e;

  state_e                state_q, state_d;
  logic                  rw_q, rw_d;
  logic [9:2]            addr_q, addr_d;
  logic                  victim_q, victim_d;
  logic [1:0]            beat_q, beat_d;
  logic                  gap_q, gap_d;

  logic [1:0][3:0][3:0]  tag_q;
  logic [1:0][3:0]       valid_q, dirty_q;
  logic [3:0]            lru_q;

  logic [3:0] tag;
  logic [1:0] idx, word;
  logic       hit0, hit1, hit_way, miss_victim;
  logic       touch, touch_way, fill_done;

  logic       ready, hit, mreq, mrw, way, we, fill_we;
  logic [9:0] maddr;
  logic [1:0] aidx, aword;

  assign tag  = addr_q[9:6];
  assign idx  = addr_q[5:4];
  assign word = addr_q[3:2];

  assign hit0        = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1        = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit_way     = !hit0;
  assign miss_victim = !valid_q[0][idx] ? 1'b0 :
                       !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    victim_d  = victim_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    touch     = 1'b0;
    touch_way = 1'b0;
    fill_done = 1'b0;
    ready     = 1'b0;
    hit       = 1'b0;
    mreq      = 1'b0;
    mrw       = 1'b0;
    maddr     = '0;
    way       = 1'b0;
    aidx      = '0;
    aword     = '0;
    we        = 1'b0;
    fill_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          rw_d    = bus.cpu_rw;
          addr_d  = bus.cpu_addr[9:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit0 || hit1) begin
          ready     = 1'b1;
          hit       = 1'b1;
          way       = hit_way;
          aidx      = idx;
          aword     = word;
          we        = rw_q;
          touch     = 1'b1;
          touch_way = hit_way;
          state_d   = S_IDLE;
        end else begin
          victim_d = miss_victim;
          beat_d   = '0;
          gap_d    = 1'b0;
          state_d  = (valid_q[miss_victim][idx] && dirty_q[miss_victim][idx])
                     ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK, S_REFILL: begin
        // gap_q forces the one idle cycle after every accepted beat,
        // including the hand-over from write-back to refill.
        mreq  = !gap_q;
        mrw   = (state_q == S_WRITEBACK);
        maddr = {(state_q == S_WRITEBACK) ? tag_q[victim_q][idx] : tag,
                 idx, beat_q, 2'b00};
        way   = victim_q;
        aidx  = idx;
        aword = beat_q;
        fill_we = (state_q == S_REFILL) && mreq && bus.mem_ack;
        gap_d = 1'b0;
        if (mreq && bus.mem_ack) begin
          gap_d  = 1'b1;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            if (state_q == S_WRITEBACK) begin
              state_d = S_REFILL;
            end else begin
              fill_done = 1'b1;
              state_d   = S_RESPOND;
            end
          end
        end
      end
      S_RESPOND: begin
        ready     = 1'b1;
        way       = victim_q;
        aidx      = idx;
        aword     = word;
        we        = rw_q;
        touch     = 1'b1;
        touch_way = victim_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      ready   = 1'b0;
      hit     = 1'b0;
      mreq    = 1'b0;
      mrw     = 1'b0;
      maddr   = '0;
      way     = 1'b0;
      aidx    = '0;
      aword   = '0;
      we      = 1'b0;
      fill_we = 1'b0;
    end
  end

  assign bus.cpu_ready   = ready;
  assign bus.cpu_hit     = hit;
  assign bus.mem_req     = mreq;
  assign bus.mem_rw      = mrw;
  assign bus.mem_addr    = maddr;
  assign bus.arr_way     = way;
  assign bus.arr_index   = aidx;
  assign bus.arr_word    = aword;
  assign bus.arr_we      = we;
  assign bus.arr_fill_we = fill_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      victim_q <= 1'b0;
      beat_q   <= '0;
      gap_q    <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      if (fill_done) begin
        tag_q[victim_q][idx]   <= tag;
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
      if (touch) begin
        lru_q[idx] <= !touch_way;
        if (rw_q) dirty_q[touch_way][idx] <= 1'b1;
      end
    end
  end
endmodule
